// File: rtl/hvsync_generator_pkg.sv
// rtl/hvsync_generator_pkg.sv - VGA 640x480@60 timing constants shared by the video blocks
package hvsync_generator_pkg;

  localparam int POS_W = 10;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  // Inclusive window test used for both sync pulses.
  function automatic logic in_window(input logic [POS_W-1:0] pos,
                                     input logic [POS_W-1:0] first,
                                     input logic [POS_W-1:0] last);
    return (pos >= first) && (pos <= last);
  endfunction

endpackage

// File: rtl/hvsync_generator_if.sv
// rtl/hvsync_generator_if.sv - raster position and sync bundle produced by hvsync_generator
interface hvsync_generator_if;
  import hvsync_generator_pkg::*;

  logic             hsync;
  logic             vsync;
  logic             display_on;
  logic [POS_W-1:0] hpos;
  logic [POS_W-1:0] vpos;

  modport master (output hsync, vsync, display_on, hpos, vpos);
  modport slave  (input  hsync, vsync, display_on, hpos, vpos);

endinterface

// File: rtl/hvsync_generator_wrap_counter.sv
// rtl/hvsync_generator_wrap_counter.sv - modulo counter with enable, next-value tap and wrap pulse
module wrap_counter #(
  parameter int WIDTH   = 10,
  parameter int MODULUS = 800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] next_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  // next_o lets a parent register decodes in step with the counter itself.
  assign next_o  = count_d;
  assign wrap_o  = en_i && (count_q == LAST);

endmodule

// File: rtl/hvsync_generator.sv
// rtl/hvsync_generator.sv - VGA raster counters with registered, zero-skew sync and visible flags
module hvsync_generator
  import hvsync_generator_pkg::*;
#(
  parameter int H_DISPLAY = hvsync_generator_pkg::H_DISPLAY,
  parameter int H_FRONT   = hvsync_generator_pkg::H_FRONT,
  parameter int H_SYNC    = hvsync_generator_pkg::H_SYNC,
  parameter int H_BACK    = hvsync_generator_pkg::H_BACK,
  parameter int V_DISPLAY = hvsync_generator_pkg::V_DISPLAY,
  parameter int V_FRONT   = hvsync_generator_pkg::V_FRONT,
  parameter int V_SYNC    = hvsync_generator_pkg::V_SYNC,
  parameter int V_BACK    = hvsync_generator_pkg::V_BACK,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  hvsync_generator_if.master  vga
);

  localparam int L_H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int L_V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [POS_W-1:0] HS_FIRST = POS_W'(H_DISPLAY + H_FRONT);
  localparam logic [POS_W-1:0] HS_LAST  = POS_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [POS_W-1:0] VS_FIRST = POS_W'(V_DISPLAY + V_FRONT);
  localparam logic [POS_W-1:0] VS_LAST  = POS_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [POS_W-1:0] H_VIS    = POS_W'(H_DISPLAY);
  localparam logic [POS_W-1:0] V_VIS    = POS_W'(V_DISPLAY);

  logic [POS_W-1:0] h_count, h_next, v_count, v_next;
  logic             h_wrap;
  logic             v_wrap_unused;

  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic display_on_q, display_on_d;

  wrap_counter #(.WIDTH(POS_W), .MODULUS(L_H_TOTAL)) u_hcount (
    .clk     (clk),
    .rst     (reset),
    .en_i    (1'b1),
    .count_o (h_count),
    .next_o  (h_next),
    .wrap_o  (h_wrap)
  );

  wrap_counter #(.WIDTH(POS_W), .MODULUS(L_V_TOTAL)) u_vcount (
    .clk     (clk),
    .rst     (reset),
    .en_i    (h_wrap),
    .count_o (v_count),
    .next_o  (v_next),
    .wrap_o  (v_wrap_unused)
  );

  // Decoding the next counter values keeps the flags aligned with hpos/vpos.
  always_comb begin
    hsync_d      = in_window(h_next, HS_FIRST, HS_LAST) ? SYNC_POL : ~SYNC_POL;
    vsync_d      = in_window(v_next, VS_FIRST, VS_LAST) ? SYNC_POL : ~SYNC_POL;
    display_on_d = (h_next < H_VIS) && (v_next < V_VIS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_q      <= ~SYNC_POL;
      vsync_q      <= ~SYNC_POL;
      display_on_q <= 1'b1;
    end else begin
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      display_on_q <= display_on_d;
    end
  end

  assign vga.hpos       = h_count;
  assign vga.vpos       = v_count;
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.display_on = display_on_q;

endmodule

// File: tb/tb_hvsync_generator.sv
// tb/tb_hvsync_generator.sv - scoreboard bench for hvsync_generator (VGA default and a reduced active-high instance)
module tb_hvsync_generator;

  typedef struct packed {
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       hs;
    logic       vs;
    logic       de;
  } exp_t;

  // Reduced timing for instance B so whole frames fit in a short run.
  localparam int BHD = 8, BHF = 2, BHS = 3, BHB = 2;
  localparam int BVD = 6, BVF = 2, BVS = 2, BVB = 3;
  localparam int BHT = BHD + BHF + BHS + BHB;
  localparam int BVT = BVD + BVF + BVS + BVB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #20 clk = ~clk;

  hvsync_generator_if if_a ();
  hvsync_generator_if if_b ();

  hvsync_generator u_dut_a (
    .clk   (clk),
    .reset (reset),
    .vga   (if_a)
  );

  hvsync_generator #(
    .H_DISPLAY(BHD), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
    .V_DISPLAY(BVD), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB),
    .SYNC_POL(1'b1)
  ) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .vga   (if_b)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int ha = 0, va = 0, hb = 0, vb = 0;
  exp_t qa[$];
  exp_t qb[$];

  logic a_hs_prev = 1'b1, a_de_prev = 1'b1, b_vs_prev = 1'b0, b_hs_prev = 1'b0;
  int a_hs_run = 0, a_hs_len = -1, a_hs_fall_h = -1, a_hs_rise_h = -1;
  int a_de_fall_h = -1, a_de_rise_h = -1;
  int b_vs_run = 0, b_vs_len = -1, b_vs_last = -1, b_vs_period = -1;
  int b_hs_run = 0, b_hs_len = -1;

  function automatic exp_t model_out(input int h, input int v,
                                     input int hd, input int hf, input int hsw,
                                     input int vd, input int vf, input int vsw,
                                     input bit pol);
    exp_t r;
    r.hpos = 10'(h);
    r.vpos = 10'(v);
    r.hs   = (h >= hd + hf && h <= hd + hf + hsw - 1) ? pol : ~pol;
    r.vs   = (v >= vd + vf && v <= vd + vf + vsw - 1) ? pol : ~pol;
    r.de   = (h < hd) && (v < vd);
    return r;
  endfunction

  function automatic exp_t exp_a();
    return model_out(ha, va, 640, 16, 96, 480, 10, 2, 1'b0);
  endfunction

  function automatic exp_t exp_b();
    return model_out(hb, vb, BHD, BHF, BHS, BVD, BVF, BVS, 1'b1);
  endfunction

  function automatic exp_t obs_a();
    return '{hpos: if_a.hpos, vpos: if_a.vpos, hs: if_a.hsync, vs: if_a.vsync, de: if_a.display_on};
  endfunction

  function automatic exp_t obs_b();
    return '{hpos: if_b.hpos, vpos: if_b.vpos, hs: if_b.hsync, vs: if_b.vsync, de: if_b.display_on};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic track();
    logic hs, de, vs, bhs;
    hs = if_a.hsync;
    de = if_a.display_on;
    if (a_hs_prev && !hs) begin a_hs_fall_h = int'(if_a.hpos); a_hs_run = 0; end
    if (!hs) a_hs_run++;
    if (!a_hs_prev && hs) begin a_hs_rise_h = int'(if_a.hpos); a_hs_len = a_hs_run; end
    a_hs_prev = hs;
    if (a_de_prev && !de) a_de_fall_h = int'(if_a.hpos);
    if (!a_de_prev && de) a_de_rise_h = int'(if_a.hpos);
    a_de_prev = de;
    vs = if_b.vsync;
    if (!b_vs_prev && vs) begin
      if (b_vs_last >= 0) b_vs_period = cyc - b_vs_last;
      b_vs_last = cyc;
      b_vs_run  = 0;
    end
    if (vs) b_vs_run++;
    if (b_vs_prev && !vs) b_vs_len = b_vs_run;
    b_vs_prev = vs;
    bhs = if_b.hsync;
    if (!b_hs_prev && bhs) b_hs_run = 0;
    if (bhs) b_hs_run++;
    if (b_hs_prev && !bhs) b_hs_len = b_hs_run;
    b_hs_prev = bhs;
  endtask

  // One clock: advance the model, push its expectation, compare at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      ha++;
      if (ha == 800) begin ha = 0; va = (va == 524) ? 0 : va + 1; end
      hb++;
      if (hb == BHT) begin hb = 0; vb = (vb == BVT - 1) ? 0 : vb + 1; end
    end
    qa.push_back(exp_a());
    qb.push_back(exp_b());
    @(negedge clk);
    cyc++;
    check("sb_a", 32'(obs_a()), 32'(qa.pop_front()));
    check("sb_b", 32'(obs_b()), 32'(qb.pop_front()));
    track();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int guard;

    reset = 1'b1;
    ticks(3);
    check("rst_a_hpos", 32'(if_a.hpos), 32'd0);
    check("rst_a_vpos", 32'(if_a.vpos), 32'd0);
    check("rst_a_de",   32'(if_a.display_on), 32'd1);
    check("rst_a_hs",   32'(if_a.hsync), 32'd1);
    check("rst_a_vs",   32'(if_a.vsync), 32'd1);
    check("rst_b_hs",   32'(if_b.hsync), 32'd0);
    check("rst_b_vs",   32'(if_b.vsync), 32'd0);

    reset = 1'b0;
    tick();
    check("first_hpos", 32'(if_a.hpos), 32'd1);

    ticks(798);
    check("line_end_hpos", 32'(if_a.hpos), 32'd799);
    check("line_end_vpos", 32'(if_a.vpos), 32'd0);
    tick();
    check("wrap_hpos", 32'(if_a.hpos), 32'd0);
    check("wrap_vpos", 32'(if_a.vpos), 32'd1);

    ticks(800);
    check("hs_fall_h", 32'(a_hs_fall_h), 32'd656);
    check("hs_rise_h", 32'(a_hs_rise_h), 32'd752);
    check("hs_len",    32'(a_hs_len),    32'd96);
    check("de_fall_h", 32'(a_de_fall_h), 32'd640);
    check("de_rise_h", 32'(a_de_rise_h), 32'd0);

    check("b_vs_len",    32'(b_vs_len),    32'(BVS * BHT));
    check("b_vs_period", 32'(b_vs_period), 32'(BHT * BVT));
    check("b_hs_len",    32'(b_hs_len),    32'(BHS));

    guard = 0;
    while (!(if_b.hpos == 10'(BHT - 1) && if_b.vpos == 10'(BVT - 1)) && guard < 400) begin
      tick();
      guard++;
    end
    check("b_frame_end_found", 32'(guard < 400), 32'd1);
    tick();
    check("b_frame_wrap_h", 32'(if_b.hpos), 32'd0);
    check("b_frame_wrap_v", 32'(if_b.vpos), 32'd0);

    guard = 0;
    while (if_a.hpos != 10'd300 && guard < 1000) begin
      tick();
      guard++;
    end
    check("mid_line_found", 32'(guard < 1000), 32'd1);
    check("mid_line_vpos_nonzero", 32'(if_a.vpos != 10'd0), 32'd1);

    // Asynchronous reset between clock edges must act without waiting for clk.
    #2 reset = 1'b1;
    #1;
    ha = 0; va = 0; hb = 0; vb = 0;
    check("async_a", 32'(obs_a()), 32'(exp_a()));
    check("async_b", 32'(obs_b()), 32'(exp_b()));
    ticks(2);
    reset = 1'b0;
    tick();
    check("restart_hpos", 32'(if_a.hpos), 32'd1);
    check("restart_vpos", 32'(if_a.vpos), 32'd0);
    ticks(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
